gpu_cmd_streamer: RTL and testbench

- Host-side feeder for vga_gpu.
- Accepts 32-bit GPU instructions from the controlling logic over a valid/ready interface and buffers them in a small FIFO.
- Serialises each instruction MSB-first into four bytes on the GPU 8-bit write bus (we/en/data, ack, busy), so the GPU's byte-level instruction decoder reassembles the original 32-bit word.
- Enforces the bus handshake, waits out GPU busy, and aborts on missing ack.

---
 rtl/gpu_bus_pkg.sv | 20 ++
 rtl/gpu_cmd_streamer_if.sv | 15 +
 rtl/gpu_cmd_fifo.sv | 59 +++++
 rtl/gpu_cmd_streamer.sv | 158 +++++++++++++++
 tb/tb_gpu_cmd_streamer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_bus_pkg.sv
// Shared definitions for the host-to-GPU byte bus: instruction geometry and
// the serialiser state encoding, reusable by vga_gpu-side blocks.
package gpu_bus_pkg;

    localparam int INSTR_W         = 32;
    localparam int BUS_WIDTH       = 8;
    localparam int BYTES_PER_INSTR = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } gpu_bus_state_t;

    // Byte that goes on the bus next: the instruction is sent MSB first.
    function automatic logic [BUS_WIDTH-1:0] top_byte(input logic [INSTR_W-1:0] w);
        return w[INSTR_W-1 -: BUS_WIDTH];
    endfunction

endpackage

// File: rtl/gpu_cmd_streamer_if.sv
// GPU 8-bit instruction write bus: the host drives we/en/data, the GPU
// answers with a per-byte ack and a busy level while it executes.
interface gpu_cmd_streamer_if;
    import gpu_bus_pkg::*;

    logic                 we;
    logic                 en;
    logic [BUS_WIDTH-1:0] data;
    logic                 ack;
    logic                 busy;

    modport master (output we, en, data, input ack, busy);
    modport slave  (input we, en, data, output ack, busy);

endinterface

// File: rtl/gpu_cmd_fifo.sv
// Synchronous instruction FIFO with occupancy count; contents are dropped
// on reset by clearing the pointers and level.
module gpu_cmd_fifo
    import gpu_bus_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = INSTR_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]    LVL_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = (r_level == LVL_FULL);
    assign o_empty = (r_level == '0);

endmodule

// File: rtl/gpu_cmd_streamer.sv
// Host-side feeder for vga_gpu: queues 32-bit instructions and serialises
// each one MSB-first onto the GPU byte bus with ack handshake and timeout.
module gpu_cmd_streamer
    import gpu_bus_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [INSTR_W-1:0]          i_cmd,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    gpu_cmd_streamer_if.master          bus,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_idle,
    output logic                        o_timeout,
    input  logic                        i_clear_err
);

    localparam int                CNT_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(ACK_TIMEOUT);
    localparam int                K_W       = $clog2(BYTES_PER_INSTR);
    localparam logic [K_W-1:0]    K_FIRST   = K_W'(BYTES_PER_INSTR - 1);

    gpu_bus_state_t               r_state;
    gpu_bus_state_t               w_state_nxt;
    logic [INSTR_W-1:0]           r_shift;
    logic [INSTR_W-1:0]           w_shift_nxt;
    logic [K_W-1:0]               r_k;
    logic [K_W-1:0]               w_k_nxt;
    logic                         r_last;
    logic                         w_last_nxt;
    logic [CNT_W-1:0]             r_cnt;
    logic [CNT_W-1:0]             w_cnt_nxt;
    logic [CNT_W-1:0]             w_cnt_inc;
    logic                         r_en;
    logic                         w_en_nxt;
    logic [BUS_WIDTH-1:0]         r_data;
    logic [BUS_WIDTH-1:0]         w_data_nxt;
    logic                         r_timeout;
    logic                         w_timeout_set;
    logic                         w_pop;
    logic [INSTR_W-1:0]           w_head;
    logic [$clog2(FIFO_DEPTH):0]  w_level;
    logic                         w_full;
    logic                         w_empty;

    gpu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_cmd_valid),
        .i_din   (i_cmd),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_cnt_inc = r_cnt + 1'b1;

    // Bus outputs are computed one cycle ahead so en/we/data come straight from flops.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_k_nxt       = r_k;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        w_en_nxt      = 1'b0;
        w_data_nxt    = r_data;
        w_pop         = 1'b0;
        w_timeout_set = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !bus.busy) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_k_nxt     = K_FIRST;
                    w_last_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_en_nxt    = 1'b1;
                    w_data_nxt  = top_byte(w_head);
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (bus.ack) begin
                    w_shift_nxt = r_shift << BUS_WIDTH;
                    w_last_nxt  = (r_k == '0);
                    w_state_nxt = ST_GAP;
                end else if (w_cnt_inc == CNT_LIMIT) begin
                    w_timeout_set = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    w_en_nxt  = 1'b1;
                end
            end
            ST_GAP: begin
                w_cnt_nxt = '0;
                if (r_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_k_nxt     = r_k - 1'b1;
                    w_en_nxt    = 1'b1;
                    w_data_nxt  = top_byte(r_shift);
                    w_state_nxt = ST_DRIVE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_k     <= '0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_k     <= w_k_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en    <= w_en_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // A new abort outranks a clear arriving in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_set) begin
            r_timeout <= 1'b1;
        end else if (i_clear_err) begin
            r_timeout <= 1'b0;
        end
    end

    assign bus.en      = r_en;
    assign bus.we      = r_en;
    assign bus.data    = r_data;
    assign o_cmd_ready = !w_full;
    assign o_level     = w_level;
    assign o_idle      = (r_state == ST_IDLE) && w_empty;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_gpu_cmd_streamer.sv
// Directed bench for gpu_cmd_streamer: a main instance with the default ack
// timeout and a second instance with a short timeout for the abort scenario.
module tb_gpu_cmd_streamer;
    import gpu_bus_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] cmd_a;
    logic        valid_a;
    logic        ready_a;
    logic [3:0]  level_a;
    logic        idle_a;
    logic        tmo_a;
    logic        clr_a;
    gpu_cmd_streamer_if bus_a();

    logic [31:0] cmd_b;
    logic        valid_b;
    logic        ready_b;
    logic [3:0]  level_b;
    logic        idle_b;
    logic        tmo_b;
    logic        clr_b;
    gpu_cmd_streamer_if bus_b();

    gpu_cmd_streamer #(.FIFO_DEPTH(DEPTH)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd(cmd_a), .i_cmd_valid(valid_a),
        .o_cmd_ready(ready_a), .bus(bus_a.master), .o_level(level_a),
        .o_idle(idle_a), .o_timeout(tmo_a), .i_clear_err(clr_a));

    gpu_cmd_streamer #(.FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd(cmd_b), .i_cmd_valid(valid_b),
        .o_cmd_ready(ready_b), .bus(bus_b.master), .o_level(level_b),
        .o_idle(idle_b), .o_timeout(tmo_b), .i_clear_err(clr_b));

    // GPU model A: ack after a programmable number of en-high cycles.
    logic        ack_en_a = 1'b0;
    logic        rand_mode_a = 1'b0;
    int          ack_dly_a = 0;
    int          rdly_a = 0;
    int          en_cnt_a = 0;
    int          max_lvl_a = 0;
    logic [7:0]  bytes_a[$];

    assign bus_a.ack = ack_en_a && bus_a.en && (en_cnt_a >= (rand_mode_a ? rdly_a : ack_dly_a));

    always @(posedge clk) begin
        en_cnt_a <= bus_a.en ? en_cnt_a + 1 : 0;
        if (rst_n && bus_a.en && bus_a.ack) begin
            bytes_a.push_back(bus_a.data);
            rdly_a <= int'($urandom_range(0, 3));
        end
    end

    always @(negedge clk) begin
        if (int'(level_a) > max_lvl_a) max_lvl_a <= int'(level_a);
    end

    // GPU model B: immediate ack while enabled.
    logic       ack_en_b = 1'b0;
    logic [7:0] bytes_b[$];

    assign bus_b.ack = ack_en_b && bus_b.en;

    always @(posedge clk) begin
        if (rst_n && bus_b.en && bus_b.ack) bytes_b.push_back(bus_b.data);
    end

    function automatic logic [31:0] word_a(input int b);
        return {bytes_a[b], bytes_a[b+1], bytes_a[b+2], bytes_a[b+3]};
    endfunction

    function automatic logic [31:0] word_b(input int b);
        return {bytes_b[b], bytes_b[b+1], bytes_b[b+2], bytes_b[b+3]};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push_a(input logic [31:0] w);
        int t;
        cmd_a = w; valid_a = 1'b1; t = 0;
        while (!ready_a && t < 200) begin @(negedge clk); t++; end
        if (!ready_a) begin
            n_cmp++; n_bad++;
            $display("FAIL push_a_ready: ready=%b required 1 within 200 cycles", ready_a);
        end
        @(negedge clk);
        valid_a = 1'b0;
    endtask

    task automatic push_b(input logic [31:0] w);
        int t;
        cmd_b = w; valid_b = 1'b1; t = 0;
        while (!ready_b && t < 200) begin @(negedge clk); t++; end
        if (!ready_b) begin
            n_cmp++; n_bad++;
            $display("FAIL push_b_ready: ready=%b required 1 within 200 cycles", ready_b);
        end
        @(negedge clk);
        valid_b = 1'b0;
    endtask

    task automatic wait_idle_a(input int budget);
        int t = 0;
        while (!idle_a && t < budget) begin @(negedge clk); t++; end
        if (!idle_a) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle_a: idle=%b required 1 within %0d cycles", idle_a, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_a = '0; valid_a = 1'b0; clr_a = 1'b0; bus_a.busy = 1'b0;
        cmd_b = '0; valid_b = 1'b0; clr_b = 1'b0; bus_b.busy = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus_a.en, bus_a.we, bus_a.data} !== 10'h000) begin
            n_bad++;
            $display("FAIL rst_bus: en/we/data=%b/%b/%h required 0/0/00", bus_a.en, bus_a.we, bus_a.data);
        end
        n_cmp++;
        if ({level_a, idle_a, tmo_a} !== 6'b0000_1_0) begin
            n_bad++;
            $display("FAIL rst_status: level/idle/tmo=%0d/%b/%b required 0/1/0", level_a, idle_a, tmo_a);
        end
        n_cmp++;
        if ({bus_b.en, level_b, idle_b, tmo_b} !== 7'b0_0000_1_0) begin
            n_bad++;
            $display("FAIL rst_b: en/level/idle/tmo=%b/%0d/%b/%b required 0/0/1/0", bus_b.en, level_b, idle_b, tmo_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ready_a, idle_a} !== 2'b11) begin
            n_bad++;
            $display("FAIL rst_release: ready/idle=%b/%b required 1/1", ready_a, idle_a);
        end
    endtask

    task automatic test_single();
        logic [9:0]  en_v;
        logic [9:0]  we_v;
        logic [31:0] dv;
        logic [7:0]  d_gap1;
        logic [7:0]  d_gap4;
        logic        idle_end;
        int          base;
        ack_en_a = 1'b1; ack_dly_a = 0; rand_mode_a = 1'b0;
        base = bytes_a.size();
        dv = '0; d_gap1 = '0; d_gap4 = '0; idle_end = 1'b0;
        push_a(32'hA1B2C3D4);
        for (int i = 0; i < 10; i++) begin
            en_v[i] = bus_a.en;
            we_v[i] = bus_a.we;
            if (bus_a.en) dv = {dv[23:0], bus_a.data};
            if (i == 2) d_gap1 = bus_a.data;
            if (i == 8) d_gap4 = bus_a.data;
            if (i == 9) idle_end = idle_a;
            @(negedge clk);
        end
        n_cmp++;
        if (en_v !== 10'h0AA) begin
            n_bad++; $display("FAIL single_en_pattern: got %b required %b", en_v, 10'h0AA);
        end
        n_cmp++;
        if (we_v !== 10'h0AA) begin
            n_bad++; $display("FAIL single_we_pattern: got %b required %b", we_v, 10'h0AA);
        end
        n_cmp++;
        if (dv !== 32'hA1B2C3D4) begin
            n_bad++; $display("FAIL single_bytes: got %h required a1b2c3d4", dv);
        end
        n_cmp++;
        if ({d_gap1, d_gap4} !== 16'hA1D4) begin
            n_bad++; $display("FAIL single_data_hold: got %h required a1d4", {d_gap1, d_gap4});
        end
        n_cmp++;
        if (idle_end !== 1'b1) begin
            n_bad++; $display("FAIL single_idle: got %b required 1", idle_end);
        end
        n_cmp++;
        if (bytes_a.size() != base + 4 || word_a(base) !== 32'hA1B2C3D4) begin
            n_bad++; $display("FAIL single_acked: count %0d word %h required 4 a1b2c3d4", bytes_a.size() - base, word_a(base));
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] bp_w[9];
        int          base;
        ack_en_a = 1'b0; ack_dly_a = 1;
        base = bytes_a.size();
        for (int i = 0; i < 9; i++) bp_w[i] = 32'h0A0B0C00 + i * 32'h01010101;
        for (int i = 0; i < 8; i++) push_a(bp_w[i]);
        n_cmp++;
        if ({level_a, ready_a} !== {4'd7, 1'b1}) begin
            n_bad++; $display("FAIL bp_after8: level/ready=%0d/%b required 7/1", level_a, ready_a);
        end
        push_a(bp_w[8]);
        n_cmp++;
        if ({level_a, ready_a} !== {4'd8, 1'b0}) begin
            n_bad++; $display("FAIL bp_after9: level/ready=%0d/%b required 8/0", level_a, ready_a);
        end
        cmd_a = 32'hDEADBEEF; valid_a = 1'b1;
        repeat (3) @(negedge clk);
        valid_a = 1'b0;
        n_cmp++;
        if ({level_a, ready_a} !== {4'd8, 1'b0}) begin
            n_bad++; $display("FAIL bp_full_hold: level/ready=%0d/%b required 8/0", level_a, ready_a);
        end
        ack_en_a = 1'b1;
        wait_idle_a(400);
        n_cmp++;
        if (bytes_a.size() != base + 36) begin
            n_bad++; $display("FAIL bp_count: got %0d bytes required 36", bytes_a.size() - base);
        end
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (word_a(base + 4 * k) !== bp_w[k]) begin
                n_bad++; $display("FAIL bp_word%0d: got %h required %h", k, word_a(base + 4 * k), bp_w[k]);
            end
        end
    endtask

    task automatic test_busy();
        int base;
        int en_seen;
        ack_en_a = 1'b1; ack_dly_a = 0;
        bus_a.busy = 1'b1;
        push_a(32'h5A5B5C5D);
        push_a(32'h6A6B6C6D);
        en_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_a.en) en_seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (en_seen != 0 || level_a !== 4'd2) begin
            n_bad++; $display("FAIL busy_hold: en cycles %0d level %0d required 0 and 2", en_seen, level_a);
        end
        base = bytes_a.size();
        bus_a.busy = 1'b0;
        en_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_a.en) en_seen++;
            if (i == 2) bus_a.busy = 1'b1;
        end
        n_cmp++;
        if (en_seen != 4 || level_a !== 4'd1) begin
            n_bad++; $display("FAIL busy_between: en cycles %0d level %0d required 4 and 1", en_seen, level_a);
        end
        n_cmp++;
        if (bytes_a.size() != base + 4 || word_a(base) !== 32'h5A5B5C5D) begin
            n_bad++; $display("FAIL busy_first_word: count %0d word %h required 4 5a5b5c5d", bytes_a.size() - base, word_a(base));
        end
        bus_a.busy = 1'b0;
        wait_idle_a(100);
        n_cmp++;
        if (bytes_a.size() != base + 8 || word_a(base + 4) !== 32'h6A6B6C6D) begin
            n_bad++; $display("FAIL busy_second_word: count %0d word %h required 8 6a6b6c6d", bytes_a.size() - base, word_a(base + 4));
        end
    endtask

    task automatic test_timeout();
        logic [7:0] en_v;
        logic [7:0] d22;
        logic [7:0] d55;
        logic       tmo_before;
        logic       tmo_after;
        int         base;
        int         t;
        d22 = '0; d55 = '0; tmo_before = 1'b0; tmo_after = 1'b0;
        bus_b.busy = 1'b1; ack_en_b = 1'b1;
        base = bytes_b.size();
        push_b(32'h11223344);
        push_b(32'h55667788);
        bus_b.busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            en_v[i] = bus_b.en;
            if (i == 1) ack_en_b = 1'b0;
            if (i == 2) d22 = bus_b.data;
            if (i == 5) tmo_before = tmo_b;
            if (i == 6) begin tmo_after = tmo_b; ack_en_b = 1'b1; end
            if (i == 7) d55 = bus_b.data;
        end
        n_cmp++;
        if (en_v !== 8'hBD) begin
            n_bad++; $display("FAIL tmo_en_pattern: got %b required %b", en_v, 8'hBD);
        end
        n_cmp++;
        if ({tmo_before, tmo_after} !== 2'b01) begin
            n_bad++; $display("FAIL tmo_flag_rise: before/after=%b/%b required 0/1", tmo_before, tmo_after);
        end
        n_cmp++;
        if ({d22, d55} !== 16'h2255) begin
            n_bad++; $display("FAIL tmo_restart_byte: got %h required 2255", {d22, d55});
        end
        t = 0;
        while (!idle_b && t < 100) begin @(negedge clk); t++; end
        n_cmp++;
        if (bytes_b.size() != base + 5 || bytes_b[base] !== 8'h11 || word_b(base + 1) !== 32'h55667788) begin
            n_bad++; $display("FAIL tmo_acked: count %0d first %h word %h required 5 11 55667788", bytes_b.size() - base, bytes_b[base], word_b(base + 1));
        end
        n_cmp++;
        if (tmo_b !== 1'b1) begin
            n_bad++; $display("FAIL tmo_sticky: got %b required 1", tmo_b);
        end
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        n_cmp++;
        if (tmo_b !== 1'b0) begin
            n_bad++; $display("FAIL tmo_clear: got %b required 0", tmo_b);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        int t;
        int en_seen;
        ack_en_a = 1'b1; ack_dly_a = 3; rand_mode_a = 1'b0;
        base = bytes_a.size();
        push_a(32'hC1C2C3C4);
        push_a(32'hD1D2D3D4);
        t = 0;
        while (!(bytes_a.size() == base + 1 && bus_a.en) && t < 50) begin @(negedge clk); t++; end
        n_cmp++;
        if (!(bytes_a.size() == base + 1 && bus_a.en && level_a === 4'd1)) begin
            n_bad++; $display("FAIL rstmid_setup: bytes %0d en %b level %0d required 1 1 1", bytes_a.size() - base, bus_a.en, level_a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus_a.en, bus_a.we} !== 2'b00) begin
            n_bad++; $display("FAIL rstmid_async: en/we=%b/%b required 0/0", bus_a.en, bus_a.we);
        end
        n_cmp++;
        if ({level_a, idle_a} !== {4'd0, 1'b1}) begin
            n_bad++; $display("FAIL rstmid_status: level/idle=%0d/%b required 0/1", level_a, idle_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus_a.en) en_seen++;
        end
        n_cmp++;
        if (en_seen != 0 || bytes_a.size() != base + 1 || bus_a.data !== 8'h00) begin
            n_bad++; $display("FAIL rstmid_residual: en cycles %0d new bytes %0d data %h required 0 1 00", en_seen, bytes_a.size() - base, bus_a.data);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_w[$];
        logic [31:0] w;
        int          base;
        ack_en_a = 1'b1; rand_mode_a = 1'b1;
        base = bytes_a.size();
        for (int i = 0; i < 20; i++) begin
            w = $urandom;
            exp_w.push_back(w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push_a(w);
        end
        wait_idle_a(2000);
        n_cmp++;
        if (bytes_a.size() != base + 80) begin
            n_bad++; $display("FAIL stream_count: got %0d bytes required 80", bytes_a.size() - base);
        end
        for (int k = 0; k < 20; k++) begin
            n_cmp++;
            if (word_a(base + 4 * k) !== exp_w[k]) begin
                n_bad++; $display("FAIL stream_word%0d: got %h required %h", k, word_a(base + 4 * k), exp_w[k]);
            end
        end
        n_cmp++;
        if (max_lvl_a > DEPTH) begin
            n_bad++; $display("FAIL stream_max_level: got %0d required <= %0d", max_lvl_a, DEPTH);
        end
        rand_mode_a = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_busy();
        test_timeout();
        test_reset_mid();
        test_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
